// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: CPU-side and target-side signals of the memory bus bridge
interface mem_bus_bridge_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int NUM_DEV = 4
);
  logic                          MemRead;
  logic                          MemWrite;
  logic [ADDR_W-1:0]             MemBus_Address;
  logic [DATA_W-1:0]             MemBus_Write_Data;
  logic [DATA_W-1:0]             MemBus_Read_Data;
  logic                          Stall;
  logic                          bus_err;
  logic                          err_clr;
  logic [NUM_DEV:0]              tgt_req;
  logic                          tgt_we;
  logic [ADDR_W-1:0]             tgt_addr;
  logic [DATA_W-1:0]             tgt_wdata;
  logic [(NUM_DEV+1)*DATA_W-1:0] tgt_rdata;
  logic [NUM_DEV:0]              tgt_ready;
  modport slave (
    input  MemRead, MemWrite, MemBus_Address, MemBus_Write_Data, err_clr, tgt_rdata, tgt_ready,
    output MemBus_Read_Data, Stall, bus_err, tgt_req, tgt_we, tgt_addr, tgt_wdata
  );
  modport master (
    output MemRead, MemWrite, MemBus_Address, MemBus_Write_Data, err_clr, tgt_rdata, tgt_ready,
    input  MemBus_Read_Data, Stall, bus_err, tgt_req, tgt_we, tgt_addr, tgt_wdata
  );
endinterface

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: decodes CPU loads/stores onto RAM + peripherals with wait states, timeout and sticky error
module mem_bus_bridge #(
  parameter int                DATA_W        = 32,
  parameter int                ADDR_W        = 32,
  parameter int                NUM_DEV       = 4,
  parameter logic [ADDR_W-1:0] DEV_BASE      = 32'h40000000,
  parameter int                DEV_SPAN_LOG2 = 4,
  parameter int                TIMEOUT       = 15,
  parameter logic [DATA_W-1:0] ERR_DATA      = 32'hDEADBEEF
) (
  input logic           clk,
  input logic           reset,
  mem_bus_bridge_if.slave bus
);
  localparam int NT = NUM_DEV + 1;
  localparam int IW = $clog2(NT);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, k;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              we_q, we_d, err_q, err_d, dec_err, req, rdy;
  always_comb begin
    k       = (bus.MemBus_Address - DEV_BASE) >> DEV_SPAN_LOG2;
    dec_err = bus.MemBus_Address >= DEV_BASE && k >= ADDR_W'(NUM_DEV);
    req     = bus.MemRead | bus.MemWrite;
    rdy     = bus.tgt_ready[idx_q];
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = (state_q == ERR) | (err_q & ~bus.err_clr);
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          addr_d  = bus.MemBus_Address;
          wdata_d = bus.MemBus_Write_Data;
          we_d    = bus.MemWrite;
          idx_d   = (bus.MemBus_Address < DEV_BASE || dec_err) ? '0 : IW'(k + 1);
          state_d = dec_err ? ERR : REQ;
        end
      end
      REQ: begin
        cnt_d   = cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
        rdata_d = rdy ? bus.tgt_rdata[idx_q*DATA_W +: DATA_W] : rdata_q;
        state_d = rdy ? DONE : (cnt_d == CW'(TIMEOUT) ? ERR : REQ);
      end
      DONE, ERR: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end
  assign bus.Stall            = (state_q == IDLE && req) || state_q == REQ;
  assign bus.tgt_req          = state_q == REQ ? NT'(1) << idx_q : '0;
  assign bus.tgt_we           = we_q;
  assign bus.tgt_addr         = addr_q;
  assign bus.tgt_wdata        = wdata_q;
  assign bus.bus_err          = err_q;
  assign bus.MemBus_Read_Data = we_q ? '0 : state_q == DONE ? rdata_q : state_q == ERR ? ERR_DATA : '0;
endmodule
